rgb_to_ycbcr_axis: RTL and testbench

- Consumes the 24-bit RGB AXI-Stream produced by the 3x3 demosaicing kernel.
- Converts each pixel to BT.601 studio-range YCbCr using fixed-point arithmetic.
- Emits the result on a 24-bit AXI-Stream for downstream compression or display stages.
- Carries tuser (start of frame) and tlast (end of line) through the pipeline with full backpressure support.

---
 rtl/rgb_to_ycbcr_axis.sv | 208 ++++++++++++++++++++
 tb/tb_rgb_to_ycbcr_axis.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_to_ycbcr_axis.sv
// rgb_to_ycbcr_axis: 3-stage RGB888 -> BT.601 studio-range YCbCr AXI-Stream converter.
// Define LINE_CHECK_EN to add a sticky per-line pixel-count check reported on line_err.
module rgb_to_ycbcr_axis #(
    parameter int Nrows = 349,
    parameter int Ncol  = 349
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    input  logic [23:0] s_axis_tdata,
    output logic        s_axis_tready,
    output logic        m_axis_tvalid,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic [23:0] m_axis_tdata,
    input  logic        m_axis_tready,
    output logic        line_err
);
    localparam int DATA_W = 8;
    localparam int COEF_W = 9;
    localparam int PROD_W = 18;
    localparam int SUM_W  = 19;

    localparam logic signed [COEF_W-1:0] C_YR  =  9'sd66;
    localparam logic signed [COEF_W-1:0] C_YG  =  9'sd129;
    localparam logic signed [COEF_W-1:0] C_YB  =  9'sd25;
    localparam logic signed [COEF_W-1:0] C_CBR = -9'sd38;
    localparam logic signed [COEF_W-1:0] C_CBG = -9'sd74;
    localparam logic signed [COEF_W-1:0] C_CBB =  9'sd112;
    localparam logic signed [COEF_W-1:0] C_CRR =  9'sd112;
    localparam logic signed [COEF_W-1:0] C_CRG = -9'sd94;
    localparam logic signed [COEF_W-1:0] C_CRB = -9'sd18;

    localparam logic signed [SUM_W-1:0] RND    = 19'sd128;
    localparam logic signed [SUM_W-1:0] OFF_Y  = 19'sd16;
    localparam logic signed [SUM_W-1:0] OFF_C  = 19'sd128;
    localparam logic signed [SUM_W-1:0] LO     = 19'sd16;
    localparam logic signed [SUM_W-1:0] HI_Y   = 19'sd235;
    localparam logic signed [SUM_W-1:0] HI_C   = 19'sd240;

    if (Ncol < 1 || Ncol > 4095 || Nrows < 1) begin : g_bad_geometry
        $error("rgb_to_ycbcr_axis: Ncol must be 1..4095 and Nrows must be positive");
    end

    function automatic logic signed [PROD_W-1:0] mul_px(input logic [DATA_W-1:0] px,
                                                         input logic signed [COEF_W-1:0] c);
        logic signed [PROD_W-1:0] a;
        logic signed [PROD_W-1:0] b;
        a = {{(PROD_W-DATA_W){1'b0}}, px};
        b = {{(PROD_W-COEF_W){c[COEF_W-1]}}, c};
        return a * b;
    endfunction

    function automatic logic signed [SUM_W-1:0] sx(input logic signed [PROD_W-1:0] v);
        return {v[PROD_W-1], v};
    endfunction

    // Sum already carries the +128 rounding term; shift floors, then offset and clamp.
    function automatic logic [DATA_W-1:0] rnd_sat(input logic signed [SUM_W-1:0] s,
                                                  input logic signed [SUM_W-1:0] off,
                                                  input logic signed [SUM_W-1:0] lo,
                                                  input logic signed [SUM_W-1:0] hi);
        logic signed [SUM_W-1:0] v;
        v = (s >>> 8) + off;
        if (v < lo) begin
            v = lo;
        end else if (v > hi) begin
            v = hi;
        end
        return v[DATA_W-1:0];
    endfunction

    logic ce;
    logic vld_p0_q, vld_p1_q, vld_p2_q;
    logic usr_p0_q, usr_p1_q, usr_p2_q;
    logic lst_p0_q, lst_p1_q, lst_p2_q;

    logic [DATA_W-1:0]        r_px, g_px, b_px;
    logic signed [PROD_W-1:0] prod_p0_d [9];
    logic signed [PROD_W-1:0] prod_p0_q [9];
    logic signed [SUM_W-1:0]  y_p1_d, cb_p1_d, cr_p1_d;
    logic signed [SUM_W-1:0]  y_p1_q, cb_p1_q, cr_p1_q;
    logic [23:0]              pix_p2_d, pix_p2_q;

    assign ce            = !vld_p2_q || m_axis_tready;
    assign s_axis_tready = ce;

    assign r_px = s_axis_tdata[23:16];
    assign g_px = s_axis_tdata[15:8];
    assign b_px = s_axis_tdata[7:0];

    // S1: nine coefficient products
    always_comb begin
        prod_p0_d[0] = mul_px(r_px, C_YR);
        prod_p0_d[1] = mul_px(g_px, C_YG);
        prod_p0_d[2] = mul_px(b_px, C_YB);
        prod_p0_d[3] = mul_px(r_px, C_CBR);
        prod_p0_d[4] = mul_px(g_px, C_CBG);
        prod_p0_d[5] = mul_px(b_px, C_CBB);
        prod_p0_d[6] = mul_px(r_px, C_CRR);
        prod_p0_d[7] = mul_px(g_px, C_CRG);
        prod_p0_d[8] = mul_px(b_px, C_CRB);
    end

    // S2: per-component sums including the rounding term
    always_comb begin
        y_p1_d  = sx(prod_p0_q[0]) + sx(prod_p0_q[1]) + sx(prod_p0_q[2]) + RND;
        cb_p1_d = sx(prod_p0_q[3]) + sx(prod_p0_q[4]) + sx(prod_p0_q[5]) + RND;
        cr_p1_d = sx(prod_p0_q[6]) + sx(prod_p0_q[7]) + sx(prod_p0_q[8]) + RND;
    end

    // S3: shift, offset and clamp into the output register
    always_comb begin
        pix_p2_d = {rnd_sat(y_p1_q,  OFF_Y, LO, HI_Y),
                    rnd_sat(cb_p1_q, OFF_C, LO, HI_C),
                    rnd_sat(cr_p1_q, OFF_C, LO, HI_C)};
    end

    // Sideband is qualified by valid so bubbles never carry stray flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            usr_p0_q <= 1'b0;
            usr_p1_q <= 1'b0;
            usr_p2_q <= 1'b0;
            lst_p0_q <= 1'b0;
            lst_p1_q <= 1'b0;
            lst_p2_q <= 1'b0;
        end else if (ce) begin
            vld_p0_q <= s_axis_tvalid;
            usr_p0_q <= s_axis_tvalid && s_axis_tuser;
            lst_p0_q <= s_axis_tvalid && s_axis_tlast;
            vld_p1_q <= vld_p0_q;
            usr_p1_q <= usr_p0_q;
            lst_p1_q <= lst_p0_q;
            vld_p2_q <= vld_p1_q;
            usr_p2_q <= usr_p1_q;
            lst_p2_q <= lst_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            prod_p0_q <= prod_p0_d;
            y_p1_q    <= y_p1_d;
            cb_p1_q   <= cb_p1_d;
            cr_p1_q   <= cr_p1_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_p2_q <= '0;
        end else if (ce) begin
            pix_p2_q <= pix_p2_d;
        end
    end

    assign m_axis_tvalid = vld_p2_q;
    assign m_axis_tuser  = usr_p2_q;
    assign m_axis_tlast  = lst_p2_q;
    assign m_axis_tdata  = pix_p2_q;

`ifdef LINE_CHECK_EN
    localparam logic [11:0] NCOL_W = 12'(Ncol);

    logic        acc;
    logic [11:0] cnt_q, cnt_d, cnt_inc;
    logic        err_q, err_d;

    assign acc = s_axis_tvalid && ce;

    // Count includes the current beat; tuser restarts at 1, 4095 saturates.
    always_comb begin
        cnt_inc = s_axis_tuser ? 12'd1 : ((cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1);
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (acc) begin
            cnt_d = cnt_inc;
            if (s_axis_tlast) begin
                if (cnt_inc != NCOL_W) begin
                    err_d = 1'b1;
                end
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign line_err = err_q;
`else
    assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_to_ycbcr_axis.sv
// Self-checking bench for rgb_to_ycbcr_axis: scoreboard against a BT.601 integer model,
// with directed colour, backpressure, sideband, async-reset and line-length scenarios.
`timescale 1ns/1ps
module tb_rgb_to_ycbcr_axis;
    localparam int NCOL = 8;
`ifdef LINE_CHECK_EN
    localparam bit LC = 1'b1;
`else
    localparam bit LC = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        s_valid, s_user, s_last, s_ready;
    logic [23:0] s_data;
    logic        m_valid, m_user, m_last, m_ready;
    logic [23:0] m_data;
    logic        line_err;

    int checks = 0;
    int errors = 0;

    rgb_to_ycbcr_axis #(.Nrows(8), .Ncol(NCOL)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_valid), .s_axis_tuser(s_user), .s_axis_tlast(s_last),
        .s_axis_tdata(s_data), .s_axis_tready(s_ready),
        .m_axis_tvalid(m_valid), .m_axis_tuser(m_user), .m_axis_tlast(m_last),
        .m_axis_tdata(m_data), .m_axis_tready(m_ready),
        .line_err(line_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=progress", nm);
    endtask

    // Reference: floor division by 256 and clamp, straight from the BT.601 integer equations.
    function automatic int fdiv256(input int t);
        if (t >= 0) return t / 256;
        return -((-t + 255) / 256);
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [23:0] model(input logic [23:0] rgb);
        int r, g, b, y, cb, cr;
        r  = int'(rgb[23:16]);
        g  = int'(rgb[15:8]);
        b  = int'(rgb[7:0]);
        y  = clampi(fdiv256(66*r + 129*g + 25*b + 128) + 16, 16, 235);
        cb = clampi(fdiv256(-38*r - 74*g + 112*b + 128) + 128, 16, 240);
        cr = clampi(fdiv256(112*r - 94*g - 18*b + 128) + 128, 16, 240);
        return {y[7:0], cb[7:0], cr[7:0]};
    endfunction

    logic [25:0] exp_q[$];
    logic [25:0] e, held;
    logic        stall_prev = 1'b0;
    int          n_out = 0;
    int          mdl_cnt = 0;
    logic        mdl_err = 1'b0;
    bit          rec_en = 1'b0;
    int          rec_n = 0;
    logic        usr_rec [64];
    logic        lst_rec [64];
    bit          rand_rdy = 1'b0;

    // Compare process: every falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
            mdl_cnt    = 0;
            mdl_err    = 1'b0;
        end else begin
            chk("tready_rule", 32'(s_ready), 32'(!m_valid || m_ready));
            chk("line_err", 32'(line_err), 32'(mdl_err));
            if (stall_prev && m_valid)
                chk("hold", 32'({m_user, m_last, m_data}), 32'(held));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'({m_user, m_last, m_data}), 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 32'({m_user, m_last, m_data}), 32'(e));
                end
                if (rec_en && rec_n < 64) begin
                    usr_rec[rec_n] = m_user;
                    lst_rec[rec_n] = m_last;
                    rec_n++;
                end
                n_out++;
            end
            stall_prev = m_valid && !m_ready;
            held       = {m_user, m_last, m_data};
            if (s_valid && s_ready) begin
                exp_q.push_back({s_user, s_last, model(s_data)});
                mdl_cnt = s_user ? 1 : ((mdl_cnt >= 4095) ? 4095 : mdl_cnt + 1);
                if (s_last) begin
                    if (LC && mdl_cnt != NCOL) mdl_err = 1'b1;
                    mdl_cnt = 0;
                end
            end
        end
    end

    // Called at posedge+1; holds the beat until accepted, returns at posedge+1.
    task automatic send(input logic [23:0] d, input logic u, input logic l);
        bit acc;
        int n;
        n = 0;
        s_valid = 1'b1; s_data = d; s_user = u; s_last = l;
        forever begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk); #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                fail("send_timeout");
                break;
            end
        end
        s_valid = 1'b0; s_user = 1'b0; s_last = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_valid) break;
            n++;
            if (n > 300) begin
                fail(nm);
                break;
            end
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic rdy_toggle();
        while (rand_rdy) begin
            @(posedge clk); #1;
            if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Beat presented in cycle 0 must appear on m_axis in cycle 3 and not before.
    task automatic lat_test(input string nm, input logic [23:0] rgb, input logic [23:0] lit);
        s_valid = 1'b1; s_data = rgb;
        @(negedge clk);
        chk({nm, "_accept"}, 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_lat1"}, 32'(m_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        chk({nm, "_lat2"}, 32'(m_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        chk({nm, "_lat3"}, 32'(m_valid), 32'd1);
        chk({nm, "_data"}, 32'(m_data), 32'(lit));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=stuck required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst = 1'b0; s_valid = 1'b1; s_user = 1'b0; s_last = 1'b0;
        s_data = 24'hFFFFFF; m_ready = 1'b1;

        chk("model_white", 32'(model(24'hFFFFFF)), 32'hEB8080);
        chk("model_black", 32'(model(24'h000000)), 32'h108080);
        chk("model_red",   32'(model(24'hFF0000)), 32'h525AF0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 32'(m_valid),  32'd0);
        chk("rst_tdata",  32'(m_data),   32'd0);
        chk("rst_tready", 32'(s_ready),  32'd1);
        chk("rst_tuser",  32'(m_user),   32'd0);
        chk("rst_tlast",  32'(m_last),   32'd0);
        chk("rst_lerr",   32'(line_err), 32'd0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        lat_test("white", 24'hFFFFFF, 24'hEB8080);
        lat_test("black", 24'h000000, 24'h108080);
        lat_test("red",   24'hFF0000, 24'h525AF0);
        drain("drain_colours");

        // Backpressure: 5-cycle stall in the middle of a 10-pixel stream.
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++) send(24'($urandom), 1'b0, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1 m_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_tvalid", 32'(m_valid), 32'd1);
                    chk("stall_tready", 32'(s_ready), 32'd0);
                end
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        drain("drain_bp");
        chk("bp_count", 32'(n_out - n0), 32'd10);

        // 4x4 frame with random downstream backpressure.
        rec_n = 0; rec_en = 1'b1; rand_rdy = 1'b1;
        fork rdy_toggle(); join_none
        for (int i = 0; i < 16; i++) send(24'($urandom), i == 0, (i % 4) == 3);
        rand_rdy = 1'b0;
        m_ready  = 1'b1;
        drain("drain_frame");
        rec_en = 1'b0;
        chk("frame_count", 32'(rec_n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("frame_tuser", 32'(usr_rec[i]), 32'(i == 0));
            chk("frame_tlast", 32'(lst_rec[i]), 32'((i % 4) == 3));
        end

        // One-pixel line: both flags on the same beat.
        rec_n = 0; rec_en = 1'b1;
        send(24'h123456, 1'b1, 1'b1);
        drain("drain_onepix");
        rec_en = 1'b0;
        chk("onepix_tuser", 32'(usr_rec[0]), 32'd1);
        chk("onepix_tlast", 32'(lst_rec[0]), 32'd1);

        // Async reset with three beats in the pipe.
        send(24'hFFFFFF, 1'b0, 1'b0);
        send(24'h000000, 1'b0, 1'b0);
        send(24'hFF0000, 1'b0, 1'b0);
        #2;
        chk("pre_rst_tvalid", 32'(m_valid), 32'd1);
        rst = 1'b0;
        #0.5;
        chk("async_tvalid", 32'(m_valid), 32'd0);
        chk("async_tdata",  32'(m_data),  32'd0);
        exp_q.delete();
        mdl_cnt = 0;
        mdl_err = 1'b0;
        #0.5;
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_tvalid", 32'(m_valid), 32'd0);
        end
        @(posedge clk); #1;

        // Line-length check: 8, then 7, then 8 pixels.
        for (int i = 0; i < NCOL; i++) send(24'($urandom), i == 0, i == NCOL - 1);
        drain("drain_line8");
        chk("lerr_good_line", 32'(line_err), 32'd0);
        for (int i = 0; i < NCOL - 1; i++) send(24'($urandom), 1'b0, i == NCOL - 2);
        drain("drain_line7");
        chk("lerr_short_line", 32'(line_err), 32'(LC));
        for (int i = 0; i < NCOL; i++) send(24'($urandom), 1'b0, i == NCOL - 1);
        drain("drain_line8b");
        chk("lerr_sticky", 32'(line_err), 32'(LC));

        // Random traffic: gaps, random flags, random backpressure.
        n0 = n_out;
        rand_rdy = 1'b1;
        fork rdy_toggle(); join_none
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(24'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
        end
        rand_rdy = 1'b0;
        m_ready  = 1'b1;
        drain("drain_random");
        chk("random_count", 32'(n_out - n0), 32'd300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
